// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes I/S/B/U/J/SHAMT/ZIMM immediates
// and delivers {imm, fmt, illegal} through a 2-entry skid FIFO with flush.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  // Immediates are built 64 bits wide and truncated, so XLEN=32 needs no
  // zero-width replication.
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh, imm_sh32, imm_z;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i    = {{52{inst[31]}}, inst[31:20]};
  assign imm_s    = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u    = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j    = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh   = RV64 ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
  assign imm_sh32 = {59'b0, inst[24:20]};
  assign imm_z    = {59'b0, inst[19:15]};

  logic [63:0] dec_imm;
  logic [2:0]  dec_fmt;
  logic        dec_ill;
  entry_t      dec_entry;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      OP_LOAD: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
      end
      OP_IMM: begin
        dec_fmt = is_shift ? FMT_SHAMT : FMT_I;
        dec_imm = is_shift ? imm_sh : imm_i;
      end
      OP_IMM32: begin
        if (!RV64) begin
          dec_ill = 1'b1;
        end else begin
          dec_fmt = is_shift ? FMT_SHAMT : FMT_I;
          dec_imm = is_shift ? imm_sh32 : imm_i;
        end
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = imm_s;
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = imm_b;
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        dec_imm = imm_u;
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        dec_imm = imm_j;
      end
      OP_SYSTEM: begin
        if (funct3[2]) begin
          dec_fmt = FMT_ZIMM;
          dec_imm = imm_z;
        end
      end
      OP_REG, OP_REG32: ;
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_entry.imm     = dec_imm[XLEN-1:0];
  assign dec_entry.fmt     = dec_fmt;
  assign dec_entry.illegal = dec_ill;

  entry_t     mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       push, pop;

  assign in_ready  = !reset && !flush && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only.
    if (reset || flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is not reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (push && dec_ill && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  entry_t head;
  assign head    = mem[rd_ptr];
  assign imm     = out_valid ? head.imm     : '0;
  assign fmt     = out_valid ? head.fmt     : FMT_NONE;
  assign illegal = out_valid ? head.illegal : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=64/CNT_W=2 and one XLEN=32/CNT_W=16
// instance driven by the same stimulus, each checked against its own expectations.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] inst;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [63:0] a_imm;
  logic [2:0]  a_fmt;
  logic [1:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_imm;
  logic [2:0]  b_fmt;
  logic [15:0] b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .inst(inst),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal), .illegal_cnt(a_cnt)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .inst(inst),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal), .illegal_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [63:0] a_imm;
    logic [2:0]  a_fmt;
    logic        a_ill;
    logic [31:0] b_imm;
    logic [2:0]  b_fmt;
    logic        b_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] i, input logic [63:0] ai, input logic [2:0] af,
                     input logic al, input logic [31:0] bi, input logic [2:0] bf,
                     input logic bl);
    vec_t v;
    v.inst = i; v.a_imm = ai; v.a_fmt = af; v.a_ill = al;
    v.b_imm = bi; v.b_fmt = bf; v.b_ill = bl;
    vecs.push_back(v);
  endtask

  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inst = '0;

    // Hand-decoded vectors: addi -1, beq -4, jal +2048, lui, slli 63,
    // sw -8, csrrwi zimm=5, ecall, add, addiw -1, jalr funct3=1, all-ones.
    add(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0);
    add(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC, 3'd3, 1'b0);
    add(32'h0010006F, 64'h0000000000000800, 3'd5, 1'b0, 32'h00000800, 3'd5, 1'b0);
    add(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0);
    add(32'h03F01093, 64'd63,               3'd6, 1'b0, 32'd31,       3'd6, 1'b0);
    add(32'hFE112C23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 32'hFFFFFFF8, 3'd2, 1'b0);
    add(32'h3002D073, 64'd5,                3'd7, 1'b0, 32'd5,        3'd7, 1'b0);
    add(32'h00000073, 64'd0,                3'd0, 1'b0, 32'd0,        3'd0, 1'b0);
    add(32'h00B50533, 64'd0,                3'd0, 1'b0, 32'd0,        3'd0, 1'b0);
    add(32'hFFF0809B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'd0,        3'd0, 1'b1);
    add(32'h00001067, 64'd0,                3'd0, 1'b1, 32'd0,        3'd0, 1'b1);
    for (int k = 0; k < 4; k++)
      add(32'hFFFFFFFF, 64'd0, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1);

    // Reset state
    @(posedge clk); #1;
    check("rst a_in_ready",  64'(a_in_ready),  64'd0);
    check("rst b_in_ready",  64'(b_in_ready),  64'd0);
    check("rst a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst a_imm",       a_imm,            64'd0);
    check("rst a_cnt",       64'(a_cnt),       64'd0);
    check("rst b_cnt",       64'(b_cnt),       64'd0);
    reset = 1'b0;
    #1;
    check("post-rst a_in_ready", 64'(a_in_ready), 64'd1);

    // Streaming decode with out_ready=1
    foreach (vecs[n]) begin
      inst = vecs[n].inst; in_valid = 1'b1;
      @(posedge clk); #1;
      if (vecs[n].a_ill) exp_cnt_a = (exp_cnt_a == 3) ? 3 : exp_cnt_a + 1;
      if (vecs[n].b_ill) exp_cnt_b++;
      check($sformatf("v%0d a_out_valid", n), 64'(a_out_valid), 64'd1);
      check($sformatf("v%0d a_imm", n),       a_imm,            vecs[n].a_imm);
      check($sformatf("v%0d a_fmt", n),       64'(a_fmt),       64'(vecs[n].a_fmt));
      check($sformatf("v%0d a_illegal", n),   64'(a_illegal),   64'(vecs[n].a_ill));
      check($sformatf("v%0d b_imm", n),       64'(b_imm),       64'(vecs[n].b_imm));
      check($sformatf("v%0d b_fmt", n),       64'(b_fmt),       64'(vecs[n].b_fmt));
      check($sformatf("v%0d b_illegal", n),   64'(b_illegal),   64'(vecs[n].b_ill));
      check($sformatf("v%0d a_cnt", n),       64'(a_cnt),       64'(exp_cnt_a));
      check($sformatf("v%0d b_cnt", n),       64'(b_cnt),       64'(exp_cnt_b));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain a_out_valid", 64'(a_out_valid), 64'd0);
    check("drain a_imm zero",  a_imm,            64'd0);
    check("a_cnt saturated",   64'(a_cnt),       64'd3);

    // Backpressure: three back-to-back, only two accepted
    out_ready = 1'b0;
    inst = 32'hFFF00093; in_valid = 1'b1;
    @(posedge clk); #1;
    inst = 32'h0010006F;
    @(posedge clk); #1;
    inst = 32'h800000B7;
    #1;
    check("full a_in_ready", 64'(a_in_ready), 64'd0);
    check("full b_in_ready", 64'(b_in_ready), 64'd0);
    check("full head fmt",   64'(a_fmt),      64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("hold a_imm", a_imm,      64'hFFFFFFFFFFFFFFFF);
    check("hold a_fmt", 64'(a_fmt), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp 2nd a_fmt", 64'(a_fmt), 64'd5);
    check("bp 2nd a_imm", a_imm,      64'h800);
    @(posedge clk); #1;
    check("bp empty a_out_valid", 64'(a_out_valid), 64'd0);
    check("bp empty a_in_ready",  64'(a_in_ready),  64'd1);

    // Flush with a full buffer and a colliding in_valid
    out_ready = 1'b0;
    inst = 32'hFFF00093; in_valid = 1'b1;
    @(posedge clk); #1;
    inst = 32'hFE000EE3;
    @(posedge clk); #1;
    check("pre-flush a_in_ready", 64'(a_in_ready), 64'd0);
    flush = 1'b1; inst = 32'h800000B7;
    #1;
    check("flush a_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("post-flush a_out_valid", 64'(a_out_valid), 64'd0);
    check("post-flush a_in_ready",  64'(a_in_ready),  64'd1);
    check("post-flush a_imm",       a_imm,            64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("flushed inst absent", 64'(a_out_valid), 64'd0);
    check("flush keeps a_cnt",   64'(a_cnt),       64'd3);
    check("flush keeps b_cnt",   64'(b_cnt),       64'(exp_cnt_b));

    // Reset mid-stream
    out_ready = 1'b0;
    inst = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_cnt_b++;
    check("mid a_illegal", 64'(a_illegal), 64'd1);
    check("mid b_cnt",     64'(b_cnt),     64'(exp_cnt_b));
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("mrst a_out_valid", 64'(a_out_valid), 64'd0);
    check("mrst a_imm",       a_imm,            64'd0);
    check("mrst a_fmt",       64'(a_fmt),       64'd0);
    check("mrst a_illegal",   64'(a_illegal),   64'd0);
    check("mrst a_cnt",       64'(a_cnt),       64'd0);
    check("mrst b_cnt",       64'(b_cnt),       64'd0);
    check("mrst a_in_ready",  64'(a_in_ready),  64'd0);
    reset = 1'b0;
    #1;
    check("mrst release a_in_ready", 64'(a_in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined RV immediate generator. It replaces the combinational sign-extend unit between instruction fetch/decode and the ALU/branch datapath. It accepts 32-bit instructions over a valid/ready handshake and decodes every base-ISA immediate format (I, S, B, U, J, shift-amount, CSR zimm). It emits the XLEN-wide extended immediate, a format code and an illegal flag through a 2-entry skid buffer with flush support and a saturating illegal-instruction counter.

Parameters:
XLEN, 64, datapath width; legal values are 32 and 64; immediates are sign- or zero-extended to XLEN.
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous pipeline flush; discards buffered entries
in_valid  in  1  inst is valid this cycle
in_ready  out  1  block can accept inst this cycle
inst  in  32  RV instruction word
out_valid  out  1  imm/fmt/illegal hold a valid entry
out_ready  in  1  consumer accepts the head entry this cycle
imm  out  XLEN  extended immediate of the head entry
fmt  out  3  format code: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
illegal  out  1  head entry has an unsupported opcode or funct3
illegal_cnt  out  CNT_W  count of accepted illegal entries, saturating

Behaviour:
- Decode by opcode inst[6:0]:
  - 0000011, 0010011, 0011011 (non-shift funct3), 1100111 with funct3=000: I format; imm = sext(inst[31:20]).
  - 1100111 with funct3 != 000: illegal.
  - 0100011: S format; imm = sext({inst[31:25], inst[11:7]}).
  - 1100011: B format; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111 and 0010111: U format; imm = sext({inst[31:12], 12'b0}). With XLEN=32 there is no extension.
  - 1101111: J format; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 0010011 with funct3 001 or 101: SHAMT format; imm = zext(inst[25:20]) when XLEN=64, zext(inst[24:20]) when XLEN=32.
  - 0011011 with funct3 001 or 101: SHAMT format; imm = zext(inst[24:20]).
  - 1110011 with funct3[2]=1: ZIMM format; imm = zext(inst[19:15]).
  - 1110011 with funct3[2]=0: fmt 0, imm 0, not illegal.
  - 0110011, 0111011: fmt 0, imm 0, not illegal.
  - 0011011 when XLEN=32: illegal.
  - Any other opcode: illegal.
- For every illegal entry: illegal=1, fmt=0, imm=0.
- Buffer: 2-entry FIFO of {imm, fmt, illegal}; occupancy count is 0..2.
  - in_ready = !reset && !flush && (count<2).
  - An entry is accepted on an edge with in_valid && in_ready. It is visible at the outputs the next cycle (latency 1) when the buffer was empty; otherwise it is queued behind older entries.
  - out_valid = (count>0). The head entry pops on an edge with out_valid && out_ready.
  - Accept and pop in the same cycle leave count unchanged; order is preserved (strict FIFO).
  - While out_valid=1 and out_ready=0, imm/fmt/illegal are held stable.
  - When count=2, in_ready=0; no accept occurs, so simultaneous push and pop cannot happen when full.
- flush: on the edge, count becomes 0 and out_valid drops next cycle. An in_valid presented in the same cycle is not accepted (in_ready=0). illegal_cnt is not cleared.
- illegal_cnt increments by 1 on each accepted illegal entry and saturates at all-ones.
- Reset: count=0, out_valid=0, imm=0, fmt=0, illegal=0, illegal_cnt=0, in_ready=0 while reset is high. Reset mid-operation discards all entries. Reset has priority over flush.
- When out_valid=0, imm/fmt/illegal read 0.

Test Plan:
- XLEN=64, inst 0xFFF00093 (addi -1) with out_ready=1 -> next cycle out_valid=1, fmt=1, imm=0xFFFFFFFFFFFFFFFF, illegal=0.
- inst 0xFE000EE3 (beq -4) -> fmt=3, imm=0xFFFFFFFFFFFFFFFC. inst 0x0010006F (jal +2048) -> fmt=5, imm=0x800.
- inst 0x800000B7 (lui) -> XLEN=64: imm=0xFFFFFFFF80000000; XLEN=32: imm=0x80000000. inst 0x03F01093 (slli 63) -> fmt=6, imm=63.
- out_ready=0, present 3 back-to-back instructions -> 2 accepted, in_ready=0 on the 3rd; release out_ready -> outputs appear in order on consecutive cycles, then in_ready=1.
- inst 0xFFFFFFFF -> illegal=1, imm=0, illegal_cnt increments by 1. With CNT_W=2, 5 illegal instructions -> illegal_cnt=3 (saturated).
- Buffer holding 2 entries, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped inst never appears. Reset asserted mid-stream -> all outputs 0 next cycle.
